rv32i_multicycle_controller: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Fetches one instruction over a ready/valid instruction-memory handshake, holds it in an internal IR and decodes the opcode into the shared immediate-format code.
- Sequences the ALU, data memory, register-file writeback and PC update, one instruction at a time.
- Traps, stickily, on an illegal opcode or a memory timeout.

---
 rtl/rv32i_multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_rv32i_multicycle_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_controller.sv
// rv32i_multicycle_controller: multi-cycle RV32I control FSM (fetch/decode/execute/mem/writeback/trap).
// Optional: define CTRL_INSTRET_EN to add the 64-bit retired-instruction counter output instret.
module rv32i_multicycle_controller #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [2:0]  imm_fmt,
    input  logic        branch_taken,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap,
    output logic [1:0]  trap_cause
`ifdef CTRL_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Counter only needs to reach MEM_TIMEOUT-1: the limit cycle itself decides the trap.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [6:0]    opcode;
    logic          is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_reg, is_nop;
    logic          at_limit, in_alu;

    // The controller itself only sequences; narrower datapaths cannot hold an RV32I word.
    if (XLEN < 32) begin : g_xlen_check
        $error("rv32i_multicycle_controller: XLEN must be at least 32");
    end

    assign opcode    = ir[6:0];
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_reg    = opcode == OP_REG;
    assign is_nop    = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);
    assign at_limit  = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1));
    assign in_alu    = (state == EXECUTE) || (state == MEM) || (state == WRITEBACK);

    // Immediate format from the latched opcode; unknown opcodes flag as illegal (111).
    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC:                              imm_fmt = 3'b100;
            OP_JAL:                                        imm_fmt = 3'b101;
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: imm_fmt = 3'b001;
            OP_BRANCH:                                     imm_fmt = 3'b011;
            OP_STORE:                                      imm_fmt = 3'b010;
            OP_REG:                                        imm_fmt = 3'b000;
            default:                                       imm_fmt = 3'b111;
        endcase
    end

    // ALU operand selects stay valid from EXECUTE through WRITEBACK so the result is stable.
    assign imem_req  = state == FETCH;
    assign dmem_req  = state == MEM;
    assign dmem_we   = (state == MEM) && is_store;
    assign alu_src_a = in_alu && (is_auipc || is_jal);
    assign alu_src_b = in_alu && !(is_reg || is_branch);
    assign rf_we     = (state == WRITEBACK) && (ir[11:7] != 5'd0);
    assign wb_sel    = (state != WRITEBACK) ? 2'b00 : is_load ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
    assign pc_we     = ((state == EXECUTE) && (is_branch || is_nop))
                     || ((state == MEM) && is_store && dmem_ready)
                     || (state == WRITEBACK);
    assign pc_sel    = ((state == EXECUTE) && is_branch && branch_taken) ? 2'b01 :
                       ((state == WRITEBACK) && is_jal)                  ? 2'b01 :
                       ((state == WRITEBACK) && is_jalr)                 ? 2'b10 : 2'b00;
    assign trap      = state == TRAP;

    // State sequencing, IR capture, handshake timeout and sticky trap cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            ir         <= '0;
            cnt        <= '0;
            trap_cause <= 2'b00;
`ifdef CTRL_INSTRET_EN
            instret    <= '0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    cnt   <= '0;
                end
                FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= DECODE;
                    end else if (at_limit) begin
                        state      <= TRAP;
                        trap_cause <= 2'b10;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODE: begin
                    if (imm_fmt == 3'b111) begin
                        state      <= TRAP;
                        trap_cause <= 2'b01;
                    end else begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    cnt <= '0;
                    if (is_branch || is_nop) state <= FETCH;
                    else if (is_load || is_store) state <= MEM;
                    else state <= WRITEBACK;
                end
                MEM: begin
                    if (dmem_ready) begin
                        state <= is_store ? FETCH : WRITEBACK;
                        cnt   <= '0;
                    end else if (at_limit) begin
                        state      <= TRAP;
                        trap_cause <= 2'b11;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITEBACK: begin
                    state <= FETCH;
                    cnt   <= '0;
                end
                default: state <= TRAP;
            endcase
`ifdef CTRL_INSTRET_EN
            if (pc_we) instret <= instret + 64'd1;
`endif
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// tb_rv32i_multicycle_controller: directed self-checking bench for the multi-cycle RV32I controller.
module tb_rv32i_multicycle_controller;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req, alu_src_a, alu_src_b, dmem_req, dmem_we, rf_we, pc_we, trap;
    logic [31:0] ir;
    logic [2:0]  imm_fmt;
    logic [1:0]  wb_sel, pc_sel, trap_cause;
`ifdef CTRL_INSTRET_EN
    logic [63:0] instret;
`endif
    int n_checks = 0, n_fail = 0;

    rv32i_multicycle_controller #(.XLEN(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir(ir), .imm_fmt(imm_fmt), .branch_taken(branch_taken),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .trap(trap), .trap_cause(trap_cause)
`ifdef CTRL_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    // Advance one state; observe 1 time unit after the falling edge, far from the rising edge.
    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Present an instruction in FETCH with zero wait; returns in DECODE.
    task automatic fetch(input logic [31:0] instr);
        imem_ready = 1'b1;
        imem_rdata = instr;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        #1;
    endtask

    // Reset through BOOT; returns in FETCH.
    task automatic do_reset;
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({imem_req, dmem_req, dmem_we, rf_we, pc_we, alu_src_a, alu_src_b, wb_sel, pc_sel, trap, trap_cause} !== 13'd0) begin n_fail++; $display("FAIL reset_outputs: got %b expected all zero", {imem_req, dmem_req, dmem_we, rf_we, pc_we, alu_src_a, alu_src_b, wb_sel, pc_sel, trap, trap_cause}); end
        n_checks++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h expected 00000000", ir); end
        n_checks++; if (imm_fmt !== 3'b111) begin n_fail++; $display("FAIL reset_imm_fmt: got %b expected 111", imm_fmt); end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_idle: imem_req got %b expected 0", imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL boot_to_fetch: imem_req got %b expected 1", imem_req); end
    endtask

    task automatic test_addi;
        imem_ready = 1'b1; imem_rdata = 32'h00500093;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL addi_fetch_req: got %b expected 1", imem_req); end
        step();
        imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (ir !== 32'h00500093) begin n_fail++; $display("FAIL addi_ir: got %h expected 00500093", ir); end
        n_checks++; if ({imm_fmt, imem_req} !== 4'b0010) begin n_fail++; $display("FAIL addi_decode: {imm_fmt,imem_req} got %b expected 0010", {imm_fmt, imem_req}); end
        step();
        imem_ready = 1'b0; imem_rdata = 32'h0;
        n_checks++; if (ir !== 32'h00500093) begin n_fail++; $display("FAIL ready_without_req: ir got %h expected 00500093", ir); end
        n_checks++; if ({alu_src_a, alu_src_b, pc_we, rf_we, imem_req} !== 5'b01000) begin n_fail++; $display("FAIL addi_execute: {src_a,src_b,pc_we,rf_we,imem_req} got %b expected 01000", {alu_src_a, alu_src_b, pc_we, rf_we, imem_req}); end
        step();
        n_checks++; if ({rf_we, wb_sel, pc_we, pc_sel, imem_req} !== 7'b1001000) begin n_fail++; $display("FAIL addi_writeback: {rf_we,wb_sel,pc_we,pc_sel,imem_req} got %b expected 1001000", {rf_we, wb_sel, pc_we, pc_sel, imem_req}); end
        step();
        n_checks++; if ({imem_req, pc_we} !== 2'b10) begin n_fail++; $display("FAIL addi_refetch_4cyc: {imem_req,pc_we} got %b expected 10", {imem_req, pc_we}); end
    endtask

    task automatic test_branch(input logic taken);
        logic [1:0] exp_sel;
        exp_sel = taken ? 2'b01 : 2'b00;
        fetch(32'h00208463);
        n_checks++; if (imm_fmt !== 3'b011) begin n_fail++; $display("FAIL beq_imm_fmt: got %b expected 011", imm_fmt); end
        step();
        branch_taken = taken;
        #1;
        n_checks++; if ({pc_we, pc_sel, rf_we, alu_src_b} !== {1'b1, exp_sel, 2'b00}) begin n_fail++; $display("FAIL beq_execute taken=%b: {pc_we,pc_sel,rf_we,src_b} got %b expected %b", taken, {pc_we, pc_sel, rf_we, alu_src_b}, {1'b1, exp_sel, 2'b00}); end
        step();
        branch_taken = 1'b0;
        #1;
        n_checks++; if ({imem_req, rf_we, pc_we} !== 3'b100) begin n_fail++; $display("FAIL beq_refetch taken=%b: {imem_req,rf_we,pc_we} got %b expected 100", taken, {imem_req, rf_we, pc_we}); end
    endtask

    task automatic test_jal_jalr;
        fetch(32'h000000EF);
        n_checks++; if (imm_fmt !== 3'b101) begin n_fail++; $display("FAIL jal_imm_fmt: got %b expected 101", imm_fmt); end
        step();
        n_checks++; if ({alu_src_a, alu_src_b, pc_we} !== 3'b110) begin n_fail++; $display("FAIL jal_execute: {src_a,src_b,pc_we} got %b expected 110", {alu_src_a, alu_src_b, pc_we}); end
        step();
        n_checks++; if ({rf_we, wb_sel, pc_we, pc_sel} !== 6'b110101) begin n_fail++; $display("FAIL jal_writeback: {rf_we,wb_sel,pc_we,pc_sel} got %b expected 110101", {rf_we, wb_sel, pc_we, pc_sel}); end
        step();
        fetch(32'h00008067);
        n_checks++; if (imm_fmt !== 3'b001) begin n_fail++; $display("FAIL jalr_imm_fmt: got %b expected 001", imm_fmt); end
        step();
        n_checks++; if ({alu_src_a, alu_src_b} !== 2'b01) begin n_fail++; $display("FAIL jalr_execute: {src_a,src_b} got %b expected 01", {alu_src_a, alu_src_b}); end
        step();
        n_checks++; if ({rf_we, wb_sel, pc_we, pc_sel} !== 6'b010110) begin n_fail++; $display("FAIL jalr_rd0_writeback: {rf_we,wb_sel,pc_we,pc_sel} got %b expected 010110", {rf_we, wb_sel, pc_we, pc_sel}); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL jalr_refetch: imem_req got %b expected 1", imem_req); end
    endtask

    task automatic test_fence;
        fetch(32'h0000000F);
        n_checks++; if (imm_fmt !== 3'b001) begin n_fail++; $display("FAIL fence_imm_fmt: got %b expected 001", imm_fmt); end
        step();
        n_checks++; if ({pc_we, pc_sel, dmem_req, rf_we} !== 5'b10000) begin n_fail++; $display("FAIL fence_execute: {pc_we,pc_sel,dmem_req,rf_we} got %b expected 10000", {pc_we, pc_sel, dmem_req, rf_we}); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fence_refetch: imem_req got %b expected 1", imem_req); end
    endtask

    task automatic test_load;
        fetch(32'h0000a103);
        n_checks++; if (imm_fmt !== 3'b001) begin n_fail++; $display("FAIL lw_imm_fmt: got %b expected 001", imm_fmt); end
        step();
        n_checks++; if ({dmem_req, alu_src_b, pc_we} !== 3'b010) begin n_fail++; $display("FAIL lw_execute: {dmem_req,src_b,pc_we} got %b expected 010", {dmem_req, alu_src_b, pc_we}); end
        step();
        for (int i = 0; i < 3; i++) begin
            dmem_ready = (i == 2);
            #1;
            n_checks++; if ({dmem_req, dmem_we, pc_we, rf_we} !== 4'b1000) begin n_fail++; $display("FAIL lw_mem_cycle%0d: {dmem_req,dmem_we,pc_we,rf_we} got %b expected 1000", i, {dmem_req, dmem_we, pc_we, rf_we}); end
            step();
        end
        dmem_ready = 1'b0;
        #1;
        n_checks++; if ({dmem_req, rf_we, wb_sel, pc_we, pc_sel} !== 7'b0101100) begin n_fail++; $display("FAIL lw_writeback: {dmem_req,rf_we,wb_sel,pc_we,pc_sel} got %b expected 0101100", {dmem_req, rf_we, wb_sel, pc_we, pc_sel}); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL lw_refetch: imem_req got %b expected 1", imem_req); end
    endtask

    task automatic test_store;
        fetch(32'h0020a023);
        n_checks++; if (imm_fmt !== 3'b010) begin n_fail++; $display("FAIL sw_imm_fmt: got %b expected 010", imm_fmt); end
        step();
        step();
        dmem_ready = 1'b0;
        #1;
        n_checks++; if ({dmem_req, dmem_we, pc_we} !== 3'b110) begin n_fail++; $display("FAIL sw_mem_wait: {dmem_req,dmem_we,pc_we} got %b expected 110", {dmem_req, dmem_we, pc_we}); end
        step();
        dmem_ready = 1'b1;
        #1;
        n_checks++; if ({dmem_we, pc_we, pc_sel, rf_we} !== 5'b11000) begin n_fail++; $display("FAIL sw_mem_ready: {dmem_we,pc_we,pc_sel,rf_we} got %b expected 11000", {dmem_we, pc_we, pc_sel, rf_we}); end
        step();
        dmem_ready = 1'b0;
        #1;
        n_checks++; if ({imem_req, rf_we, dmem_req} !== 3'b100) begin n_fail++; $display("FAIL sw_no_writeback: {imem_req,rf_we,dmem_req} got %b expected 100", {imem_req, rf_we, dmem_req}); end
    endtask

    task automatic test_illegal;
        fetch(32'h00000000);
        n_checks++; if ({imm_fmt, trap} !== 4'b1110) begin n_fail++; $display("FAIL illegal_decode: {imm_fmt,trap} got %b expected 1110", {imm_fmt, trap}); end
        step();
        n_checks++; if ({trap, trap_cause} !== 3'b101) begin n_fail++; $display("FAIL illegal_trap: {trap,cause} got %b expected 101", {trap, trap_cause}); end
        for (int i = 0; i < 20; i++) begin
            imem_ready = i[0];
            step();
            n_checks++; if ({trap, trap_cause, imem_req, pc_we} !== 5'b10100) begin n_fail++; $display("FAIL illegal_sticky_%0d: {trap,cause,imem_req,pc_we} got %b expected 10100", i, {trap, trap_cause, imem_req, pc_we}); end
        end
        do_reset();
        n_checks++; if ({trap, trap_cause, imem_req} !== 4'b0001) begin n_fail++; $display("FAIL illegal_cleared: {trap,cause,imem_req} got %b expected 0001", {trap, trap_cause, imem_req}); end
    endtask

    task automatic test_fetch_timeout;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({imem_req, trap} !== 2'b10) begin n_fail++; $display("FAIL ifetch_wait_%0d: {imem_req,trap} got %b expected 10", i, {imem_req, trap}); end
            step();
        end
        n_checks++; if ({trap, trap_cause, imem_req} !== 4'b1100) begin n_fail++; $display("FAIL ifetch_timeout: {trap,cause,imem_req} got %b expected 1100", {trap, trap_cause, imem_req}); end
        do_reset();
    endtask

    task automatic test_timeout_boundary;
        for (int i = 0; i < 3; i++) step();
        imem_ready = 1'b1; imem_rdata = 32'h00500093;
        step();
        imem_ready = 1'b0; imem_rdata = 32'h0;
        #1;
        n_checks++; if ({trap, imm_fmt} !== 4'b0001) begin n_fail++; $display("FAIL ifetch_ready_at_limit: {trap,imm_fmt} got %b expected 0001", {trap, imm_fmt}); end
        step(); step(); step();
        fetch(32'h0000a103);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            step();
        end
        dmem_ready = 1'b0;
        #1;
        n_checks++; if ({trap, rf_we, wb_sel} !== 4'b0101) begin n_fail++; $display("FAIL dmem_ready_at_limit: {trap,rf_we,wb_sel} got %b expected 0101", {trap, rf_we, wb_sel}); end
        step();
    endtask

    task automatic test_dmem_timeout;
        fetch(32'h0020a023);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if ({dmem_req, trap} !== 2'b10) begin n_fail++; $display("FAIL dmem_wait_%0d: {dmem_req,trap} got %b expected 10", i, {dmem_req, trap}); end
            step();
        end
        n_checks++; if ({trap, trap_cause, dmem_req, pc_we} !== 5'b11100) begin n_fail++; $display("FAIL dmem_timeout: {trap,cause,dmem_req,pc_we} got %b expected 11100", {trap, trap_cause, dmem_req, pc_we}); end
    endtask

    task automatic test_midreset;
        do_reset();
        fetch(32'h0000a103);
        step(); step();
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL midreset_in_mem: dmem_req got %b expected 1", dmem_req); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({dmem_req, imm_fmt, ir} !== {1'b0, 3'b111, 32'h0}) begin n_fail++; $display("FAIL midreset_async: {dmem_req,imm_fmt,ir} got %b_%b_%h expected 0_111_00000000", dmem_req, imm_fmt, ir); end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_boot: imem_req got %b expected 0", imem_req); end
        step();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midreset_fetch: imem_req got %b expected 1", imem_req); end
    endtask

`ifdef CTRL_INSTRET_EN
    task automatic test_instret;
        n_checks++; if (instret !== 64'd0) begin n_fail++; $display("FAIL instret_reset: got %0d expected 0", instret); end
        fetch(32'h00500093);
        step(); step(); step();
        n_checks++; if (instret !== 64'd1) begin n_fail++; $display("FAIL instret_addi: got %0d expected 1", instret); end
        fetch(32'h0000000F);
        step(); step();
        n_checks++; if (instret !== 64'd2) begin n_fail++; $display("FAIL instret_fence: got %0d expected 2", instret); end
        fetch(32'h00000000);
        for (int i = 0; i < 6; i++) step();
        n_checks++; if ({trap, instret} !== {1'b1, 64'd2}) begin n_fail++; $display("FAIL instret_frozen: {trap,instret} got %b/%0d expected 1/2", trap, instret); end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jal_jalr();
        test_fence();
        test_load();
        test_store();
        test_illegal();
        test_fetch_timeout();
        test_timeout_boundary();
        test_dmem_timeout();
        test_midreset();
`ifdef CTRL_INSTRET_EN
        test_instret();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
